// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch stage
package fetch_pkg;
  localparam int unsigned PC_STEP       = 4;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy outputs
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/stage_if_fetch.sv
// rtl/stage_if_fetch.sv - credit-limited instruction fetch with in-order response queue
module stage_if_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic [31:0] pcOut,
  output logic [31:0] inst,
  output logic        instValid
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_req_q, pc_req_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] outstanding, data_count;
  logic [31:0]   tag_addr;
  logic          tag_empty, tag_full, data_empty, data_full;
  logic          credit_ok, req_fire, resp_ok, data_push, data_pop;
  fetch_entry_t  head, push_entry;
  logic          unused_flags;

  assign unused_flags = ^{tag_empty, tag_full, data_full};

  // Credits count both in-flight requests and buffered words, so a freeze can never overflow the queue.
  assign credit_ok    = ({1'b0, outstanding} + {1'b0, data_count}) < (CW+1)'(DEPTH);
  assign imemReqValid = !branchTaken && credit_ok;
  assign imemAddr     = pc_req_q;
  assign req_fire     = imemReqValid && imemReqReady;
  assign resp_ok      = imemRespValid && (outstanding != '0);

  assign data_push  = resp_ok && (drop_cnt_q == '0) && !branchTaken;
  assign data_pop   = instValid && !freeze && !branchTaken;
  assign push_entry = '{pc: tag_addr + 32'(PC_STEP), inst: imemRespData};

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_req_q),
    .pop_i   (resp_ok),
    .rdata_o (tag_addr),
    .count_o (outstanding),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (branchTaken),
    .push_i  (data_push),
    .wdata_i (push_entry),
    .pop_i   (data_pop),
    .rdata_o (head),
    .count_o (data_count),
    .empty_o (data_empty),
    .full_o  (data_full)
  );

  assign instValid = !data_empty;
  assign pcOut     = data_empty ? 32'd0 : head.pc;
  assign inst      = data_empty ? 32'd0 : head.inst;

  always_comb begin
    pc_req_d   = pc_req_q;
    drop_cnt_d = drop_cnt_q;
    if (branchTaken) begin
      pc_req_d   = branchAddr;
      drop_cnt_d = outstanding - {{(CW-1){1'b0}}, resp_ok};
    end else begin
      if (req_fire) pc_req_d = pc_req_q + 32'(PC_STEP);
      if (resp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_req_q   <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_req_q   <= pc_req_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  resp_without_request_a: assert property (@(posedge clk) disable iff (!rst)
    imemRespValid |-> (outstanding != '0));
endmodule

// File: tb/tb_stage_if_fetch.sv
// tb/tb_stage_if_fetch.sv - self-checking bench for stage_if_fetch
module tb_stage_if_fetch;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'd0;

  logic        clk = 1'b0, rst = 1'b0, freeze = 1'b0, branchTaken = 1'b0;
  logic [31:0] branchAddr = 32'd0;
  logic        imemReqReady = 1'b1, imemRespValid = 1'b0;
  logic [31:0] imemRespData = 32'd0;
  logic        imemReqValid, instValid;
  logic [31:0] imemAddr, pcOut, inst;

  stage_if_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken), .branchAddr(branchAddr),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .pcOut(pcOut), .inst(inst), .instValid(instValid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

  int          total = 0, bad = 0, cyc = 0, lat = 1;
  bit          chk_en = 0;
  ent_t        m_out[$];
  logic [31:0] m_fly[$];
  bit          m_stale[$];
  logic [31:0] m_pc, exp_pop;
  logic [31:0] mem_a[$];
  int          mem_due[$];
  logic        s_hs, s_resp, s_br, s_frz, s_rstn, exp_rv, mv_have;
  logic [31:0] s_addr, s_data, s_baddr, mv_a;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_out.delete(); m_fly.delete(); m_stale.delete();
    m_pc = RST_PC; exp_pop = RST_PC + 32'd4;
  endtask

  // Sample mid-cycle and compare DUT outputs against the queue model.
  always @(negedge clk) begin
    s_hs = imemReqValid && imemReqReady; s_addr = imemAddr;
    s_resp = imemRespValid; s_data = imemRespData;
    s_br = branchTaken; s_baddr = branchAddr; s_frz = freeze; s_rstn = rst;
    if (chk_en) begin
      exp_rv = !branchTaken && ((m_fly.size() + m_out.size()) < DEPTH);
      chk("req_valid", 32'(imemReqValid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imemAddr, m_pc);
      chk("inst_valid", 32'(instValid), 32'(m_out.size() != 0));
      chk("pc_out", pcOut, (m_out.size() != 0) ? m_out[0].pc : 32'd0);
      chk("inst", inst, (m_out.size() != 0) ? m_out[0].w : 32'd0);
      if (rst && instValid && !freeze && !branchTaken) begin
        chk("pop_seq", pcOut, exp_pop);
        chk("pop_word", inst, word_of(exp_pop - 32'd4));
        exp_pop += 32'd4;
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      if (!rst) model_reset();
      else begin
        mv_have = 1'b0;
        if (s_resp && m_fly.size() > 0) begin
          mv_a = m_fly[0]; mv_have = !m_stale[0];
          m_fly.delete(0); m_stale.delete(0);
        end
        if (s_br) begin
          m_out.delete();
          foreach (m_stale[i]) m_stale[i] = 1'b1;
          m_pc = s_baddr; exp_pop = s_baddr + 32'd4;
        end else begin
          if (m_out.size() > 0 && !s_frz) m_out.delete(0);
          if (mv_have) m_out.push_back('{mv_a + 32'd4, s_data});
          if (s_hs) begin m_fly.push_back(m_pc); m_stale.push_back(1'b0); m_pc += 32'd4; end
        end
      end
    end
  end

  // Advance one cycle; the bench memory answers each accepted request after lat cycles.
  task automatic step();
    @(posedge clk); #1; cyc++;
    if (s_hs && s_rstn && rst) begin mem_a.push_back(s_addr); mem_due.push_back(cyc - 1 + lat); end
    if (mem_a.size() > 0 && mem_due[0] <= cyc) begin
      imemRespValid = 1'b1; imemRespData = word_of(mem_a[0]);
      mem_a.delete(0); mem_due.delete(0);
    end else begin
      imemRespValid = 1'b0; imemRespData = 32'd0;
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic apply_reset();
    rst = 1'b0; imemRespValid = 1'b0; imemRespData = 32'd0;
    mem_a.delete(); mem_due.delete(); model_reset();
  endtask

  task automatic rel_reset();
    step();
    rst = 1'b1; freeze = 1'b0; branchTaken = 1'b0; imemReqReady = 1'b1; cyc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    apply_reset(); chk_en = 1; step();
    #3;
    chk("rst_inst_valid", 32'(instValid), 32'd0);
    chk("rst_pc_out", pcOut, 32'd0);
    chk("rst_inst", inst, 32'd0);

    // free-running fetch, 1-cycle memory
    lat = 1; rel_reset(); #3;
    chk("t1_c1_req_valid", 32'(imemReqValid), 32'd1);
    chk("t1_c1_addr", imemAddr, RST_PC);
    goto_cyc(3); #3;
    chk("t1_c3_valid", 32'(instValid), 32'd1);
    chk("t1_c3_pc", pcOut, 32'd4);
    chk("t1_c3_inst", inst, word_of(32'd0));
    goto_cyc(4); #3;
    chk("t1_c4_pc", pcOut, 32'd8);

    // freeze for five cycles on the word fetched from 8
    goto_cyc(5); freeze = 1'b1; #3;
    chk("t2_c5_pc", pcOut, 32'd12);
    for (int c = 6; c <= 9; c++) begin
      goto_cyc(c); #3;
      chk("t2_hold_pc", pcOut, 32'd12);
      chk("t2_hold_inst", inst, word_of(32'd8));
      if (c == 7) chk("t2_credits_out", 32'(imemReqValid), 32'd0);
    end
    goto_cyc(10); freeze = 1'b0; #3;
    chk("t2_c10_pc", pcOut, 32'd12);
    goto_cyc(11); #3;
    chk("t2_c11_req_valid", 32'(imemReqValid), 32'd1);
    chk("t2_c11_addr", imemAddr, 32'd24);
    chk("t2_c11_pc", pcOut, 32'd16);
    goto_cyc(14); #3;
    chk("t2_c14_pc", pcOut, 32'd28);

    // branch with two fetches in flight, 3-cycle memory
    step(); apply_reset(); lat = 3; step(); rel_reset();
    goto_cyc(3); branchTaken = 1'b1; branchAddr = 32'h100; #3;
    chk("t3_branch_req_masked", 32'(imemReqValid), 32'd0);
    goto_cyc(4); branchTaken = 1'b0; #3;
    chk("t3_redirect_valid", 32'(imemReqValid), 32'd1);
    chk("t3_redirect_addr", imemAddr, 32'h100);
    for (int c = 5; c <= 7; c++) begin
      goto_cyc(c); #3;
      chk("t3_drop_bubble", 32'(instValid), 32'd0);
    end
    goto_cyc(8); #3;
    chk("t3_first_pc", pcOut, 32'h104);
    chk("t3_first_inst", inst, word_of(32'h100));

    // branch, response and freeze in the same cycle
    step(); apply_reset(); lat = 1; step(); rel_reset();
    goto_cyc(3); branchTaken = 1'b1; branchAddr = 32'h100; freeze = 1'b1; #3;
    chk("t4_c3_valid", 32'(instValid), 32'd1);
    chk("t4_c3_pc", pcOut, 32'd4);
    chk("t4_c3_resp", 32'(imemRespValid), 32'd1);
    goto_cyc(4); branchTaken = 1'b0; freeze = 1'b0; #3;
    chk("t4_c4_empty", 32'(instValid), 32'd0);
    chk("t4_c4_addr", imemAddr, 32'h100);
    goto_cyc(5); #3;
    chk("t4_c5_empty", 32'(instValid), 32'd0);
    goto_cyc(6); #3;
    chk("t4_c6_pc", pcOut, 32'h104);

    // memory back-pressure
    goto_cyc(7); imemReqReady = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      goto_cyc(c); #3;
      chk("t5_held_valid", 32'(imemReqValid), 32'd1);
      chk("t5_held_addr", imemAddr, 32'h10C);
    end
    goto_cyc(10); imemReqReady = 1'b1; #3;
    chk("t5_c10_addr", imemAddr, 32'h10C);
    goto_cyc(11); #3;
    chk("t5_c11_addr", imemAddr, 32'h110);

    // reset while words are buffered and two requests are outstanding
    step(); apply_reset(); lat = 2; step(); rel_reset(); freeze = 1'b1;
    goto_cyc(5); #1;
    chk("t6_pre_valid", 32'(instValid), 32'd1);
    chk("t6_pre_pc", pcOut, 32'd4);
    apply_reset(); #1;
    chk("t6_rst_valid", 32'(instValid), 32'd0);
    chk("t6_rst_pc", pcOut, 32'd0);
    chk("t6_rst_inst", inst, 32'd0);
    step(); step(); lat = 1; rel_reset(); #3;
    chk("t6_restart_addr", imemAddr, RST_PC);
    chk("t6_restart_empty", 32'(instValid), 32'd0);
    goto_cyc(3); #3;
    chk("t6_restart_pc", pcOut, 32'd4);
    goto_cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
